// File: rtl/fpu_host_if.sv
// Host-side byte register file and command sequencer for the FPU core.
// Handles operand assembly, start/done handshake, watchdog and irq ack.
module fpu_host_if #(
  parameter int          CORE_TIMEOUT = 1024,
  parameter int          TIMEOUT_W    = $clog2(CORE_TIMEOUT + 1),
  parameter logic [31:0] NAN_VALUE    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [7:0]  databus_in,
  output logic [7:0]  databus_out,
  input  logic [3:0]  addr,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic        end_ack,
  output logic        cmd_end,
  output logic        busy,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [7:0]  core_op,
  output logic        core_start,
  input  logic        core_done,
  input  logic [31:0] core_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr_q;
  logic                  r_rd_q;
  logic [31:0]           r_a;
  logic [31:0]           r_b;
  logic [31:0]           r_res;
  logic [7:0]            r_op;
  logic                  r_ovr;
  logic                  r_tmo;
  logic [TIMEOUT_W-1:0]  r_wd;

  logic w_wr_edge;
  logic w_rd_edge;
  logic w_wr_op;
  logic w_wr_ab;
  logic w_idle;
  logic w_wd_exp;

  // Edge detect makes a long strobe count as a single access.
  assign w_wr_edge = !cs && !wr && r_wr_q;
  assign w_rd_edge = !cs && !rd && r_rd_q;
  assign w_wr_op   = w_wr_edge && (addr == 4'h8);
  assign w_wr_ab   = w_wr_edge && (addr <= 4'h7);
  assign w_idle    = (r_state == S_IDLE);
  assign w_wd_exp  = (r_wd == TIMEOUT_W'(CORE_TIMEOUT - 1));

  assign core_a  = r_a;
  assign core_b  = r_b;
  assign core_op = r_op;

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    core_start = 1'b0;
    cmd_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_op) w_next = S_START;
      end
      S_START: begin
        busy       = 1'b1;
        core_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (core_done || w_wd_exp) w_next = S_DONE;
      end
      S_DONE: begin
        cmd_end = 1'b1;
        if (end_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_wr_q  <= 1'b1;
      r_rd_q  <= 1'b1;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_ovr   <= 1'b0;
      r_tmo   <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_state <= w_next;
      r_wr_q  <= wr;
      r_rd_q  <= rd;
      if (w_wr_ab && w_idle) begin
        if (addr[2]) r_b[8*addr[1:0] +: 8] <= databus_in;
        else         r_a[8*addr[1:0] +: 8] <= databus_in;
      end
      if (w_wr_op && w_idle) r_op <= databus_in;
      if (r_state == S_START)     r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
      // A real completion beats a coincident watchdog expiry.
      if (r_state == S_WAIT) begin
        if (core_done) begin
          r_res <= core_result;
          r_tmo <= 1'b0;
        end else if (w_wd_exp) begin
          r_res <= NAN_VALUE;
          r_tmo <= 1'b1;
        end
      end
      if ((w_wr_op || w_wr_ab) && !w_idle)   r_ovr <= 1'b1;
      else if (w_rd_edge && addr == 4'hD)     r_ovr <= 1'b0;
    end
  end

  always_comb begin
    databus_out = 8'h00;
    if (!cs && !rd) begin
      case (addr)
        4'h9:    databus_out = r_res[7:0];
        4'hA:    databus_out = r_res[15:8];
        4'hB:    databus_out = r_res[23:16];
        4'hC:    databus_out = r_res[31:24];
        4'hD:    databus_out = {5'b0, r_tmo, r_ovr, busy};
        default: databus_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_host_if.sv
// Directed bench for fpu_host_if: vector tables plus sequences
// for overrun, watchdog expiry, long write strobe and mid-op reset.
module tb_fpu_host_if;

  logic        clk = 1'b0;
  logic        arst;
  logic [7:0]  databus_in;
  logic [7:0]  databus_out;
  logic [3:0]  addr;
  logic        cs;
  logic        rd;
  logic        wr;
  logic        end_ack;
  logic        cmd_end;
  logic        busy;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [7:0]  core_op;
  logic        core_start;
  logic        core_done;
  logic [31:0] core_result;

  always #5 clk = ~clk;

  fpu_host_if #(.CORE_TIMEOUT(16)) dut (
    .clk(clk), .arst(arst),
    .databus_in(databus_in), .databus_out(databus_out),
    .addr(addr), .cs(cs), .rd(rd), .wr(wr),
    .end_ack(end_ack), .cmd_end(cmd_end), .busy(busy),
    .core_a(core_a), .core_b(core_b), .core_op(core_op),
    .core_start(core_start), .core_done(core_done),
    .core_result(core_result)
  );

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;

  always @(posedge clk) if (core_start === 1'b1) start_cnt <= start_cnt + 1;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", nm, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    wr = 1'b1; cs = 1'b1;
  endtask

  task automatic rd_byte(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b0; rd = 1'b0;
    #1 d = databus_out;
    @(negedge clk);
    rd = 1'b1; cs = 1'b1;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a,
                        input logic [7:0] e);
    logic [7:0] d;
    rd_byte(a, d);
    chk($sformatf("%s rd%h", nm, a), {24'h0, d}, {24'h0, e});
  endtask

  task automatic rd_res(input string nm, input logic [31:0] e);
    logic [31:0] v;
    v = e;
    rd_chk(nm, 4'h9, v[7:0]);
    rd_chk(nm, 4'hA, v[15:8]);
    rd_chk(nm, 4'hB, v[23:16]);
    rd_chk(nm, 4'hC, v[31:24]);
  endtask

  task automatic ack(input string nm);
    @(negedge clk);
    end_ack = 1'b1;
    @(negedge clk);
    end_ack = 1'b0;
    chk({nm, " cmd_end fall"}, {31'h0, cmd_end}, 32'h0);
  endtask

  vec_t wv[8];
  vec_t rv[10];

  initial begin
    int s0;
    int cnt;
    int seen;
    logic [7:0] d;

    wv[0] = '{4'h0, 8'h25}; wv[1] = '{4'h1, 8'h32};
    wv[2] = '{4'h2, 8'hA2}; wv[3] = '{4'h3, 8'h44};
    wv[4] = '{4'h4, 8'h25}; wv[5] = '{4'h5, 8'h32};
    wv[6] = '{4'h6, 8'hA2}; wv[7] = '{4'h7, 8'h44};
    rv[0] = '{4'h9, 8'h25}; rv[1] = '{4'hA, 8'h32};
    rv[2] = '{4'hB, 8'h22}; rv[3] = '{4'hC, 8'h45};
    rv[4] = '{4'hD, 8'h00}; rv[5] = '{4'h0, 8'h00};
    rv[6] = '{4'h3, 8'h00}; rv[7] = '{4'h8, 8'h00};
    rv[8] = '{4'hE, 8'h00}; rv[9] = '{4'hF, 8'h00};

    arst = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0;
    addr = 4'h0; databus_in = 8'h00;
    core_done = 1'b0; core_result = 32'h0;
    repeat (3) @(negedge clk);
    arst = 1'b0;

    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst cmd_end", {31'h0, cmd_end}, 32'h0);
    chk("rst core_start", {31'h0, core_start}, 32'h0);
    chk("rst core_a", core_a, 32'h0);
    chk("rst core_b", core_b, 32'h0);
    chk("rst core_op", {24'h0, core_op}, 32'h0);
    rd_chk("rst", 4'hD, 8'h00);

    // Test 1: normal operation
    for (int i = 0; i < 8; i++) wr_byte(wv[i].a, wv[i].d);
    s0 = start_cnt;
    wr_byte(4'h8, 8'h01);
    chk("t1 core_start", {31'h0, core_start}, 32'h1);
    chk("t1 busy", {31'h0, busy}, 32'h1);
    chk("t1 core_a", core_a, 32'h44A23225);
    chk("t1 core_b", core_b, 32'h44A23225);
    chk("t1 core_op", {24'h0, core_op}, 32'h01);
    repeat (4) @(negedge clk);
    chk("t1 no early end", {31'h0, cmd_end}, 32'h0);
    core_done = 1'b1; core_result = 32'h45223225;
    @(negedge clk);
    core_done = 1'b0; core_result = 32'hDEADBEEF;
    chk("t1 cmd_end", {31'h0, cmd_end}, 32'h1);
    chk("t1 busy low", {31'h0, busy}, 32'h0);
    chk("t1 one start", start_cnt - s0, 32'd1);
    for (int i = 0; i < 10; i++) rd_chk("t1 tbl", rv[i].a, rv[i].d);

    // Test 2: acknowledge
    @(negedge clk);
    end_ack = 1'b1;
    #1 chk("t2 end held", {31'h0, cmd_end}, 32'h1);
    @(negedge clk);
    end_ack = 1'b0;
    chk("t2 cmd_end fall", {31'h0, cmd_end}, 32'h0);
    chk("t2 busy", {31'h0, busy}, 32'h0);
    rd_chk("t2 status", 4'hD, 8'h00);
    @(negedge clk);
    core_done = 1'b1; core_result = 32'h12345678;
    @(negedge clk);
    core_done = 1'b0;
    rd_res("t2 stray done", 32'h45223225);

    // Test 4: writes while busy
    s0 = start_cnt;
    wr_byte(4'h8, 8'h03);
    chk("t4 core_start", {31'h0, core_start}, 32'h1);
    wr_byte(4'h8, 8'h04);
    wr_byte(4'h0, 8'hFF);
    chk("t4 core_a held", core_a, 32'h44A23225);
    chk("t4 core_op held", {24'h0, core_op}, 32'h03);
    rd_chk("t4 status1", 4'hD, 8'h03);
    rd_chk("t4 status2", 4'hD, 8'h01);
    chk("t4 one start", start_cnt - s0, 32'd1);
    @(negedge clk);
    core_done = 1'b1; core_result = 32'h40000000;
    @(negedge clk);
    core_done = 1'b0;
    chk("t4 cmd_end", {31'h0, cmd_end}, 32'h1);
    rd_res("t4 res", 32'h40000000);
    ack("t4");

    // Test 3: watchdog expiry
    wr_byte(4'h8, 8'h02);
    chk("t3 core_start", {31'h0, core_start}, 32'h1);
    cnt = 0;
    while (cmd_end !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("t3 latency", cnt, 32'd17);
    rd_res("t3 nan", 32'h7FC00000);
    rd_chk("t3 status", 4'hD, 8'h04);
    ack("t3");

    // Test 6: done coincident with expiry
    wr_byte(4'h8, 8'h05);
    chk("t6 core_start", {31'h0, core_start}, 32'h1);
    repeat (16) @(negedge clk);
    chk("t6 no early end", {31'h0, cmd_end}, 32'h0);
    core_done = 1'b1; core_result = 32'h3F800000;
    @(negedge clk);
    core_done = 1'b0;
    chk("t6 cmd_end", {31'h0, cmd_end}, 32'h1);
    rd_res("t6 res", 32'h3F800000);
    rd_chk("t6 status", 4'hD, 8'h00);
    ack("t6");

    // Test 5: long write strobe, then reset mid-op
    s0 = start_cnt;
    @(negedge clk);
    addr = 4'h8; databus_in = 8'h06; cs = 1'b0; wr = 1'b0;
    repeat (4) @(negedge clk);
    wr = 1'b1; cs = 1'b1;
    chk("t5 one start", start_cnt - s0, 32'd1);
    chk("t5 busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    addr = 4'hC; cs = 1'b0; rd = 1'b0; arst = 1'b1;
    #1;
    chk("t5 rst busy", {31'h0, busy}, 32'h0);
    chk("t5 rst cmd_end", {31'h0, cmd_end}, 32'h0);
    chk("t5 rst start", {31'h0, core_start}, 32'h0);
    chk("t5 rst core_a", core_a, 32'h0);
    chk("t5 rst core_b", core_b, 32'h0);
    chk("t5 rst core_op", {24'h0, core_op}, 32'h0);
    chk("t5 rst dbus", {24'h0, databus_out}, 32'h0);
    repeat (2) @(negedge clk);
    arst = 1'b0; rd = 1'b1; cs = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (cmd_end === 1'b1 || busy === 1'b1) seen = 1;
    end
    chk("t5 no cmd_end", seen, 32'd0);
    rd_chk("t5 status", 4'hD, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
